imem_loader: RTL and testbench

Boot-time program loader upstream of the CPU. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive word addresses starting at 0. The CPU is held in reset until the image is fully written and a configurable settle delay has elapsed. This replaces the bench-side `$readmemh` preload with a synthesizable path.

---
 rtl/imem_loader_pkg.sv | 43 ++++
 rtl/imem_loader_cksum.sv | 46 ++++
 rtl/imem_loader.sv | 211 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the boot-time instruction-memory loader.
//   - FSM state encoding (ERR exists only when IMEM_LOADER_CHECKSUM_EN is
//     defined; otherwise the state fits in two bits).
//   - IMEM_LOADER_HOLD_DEFAULT : default settle delay before CPU release.
//   - IMEM_LOADER_CKSUM_SEED   : initial value of the XOR checksum.
//   - state_can_start()        : states in which a new load may be started.
//   Build option: `define IMEM_LOADER_CHECKSUM_EN enables the trailing
//   checksum word and the ERR state.
package imem_loader_pkg;

  localparam int          IMEM_LOADER_HOLD_DEFAULT = 4;
  localparam logic [31:0] IMEM_LOADER_CKSUM_SEED   = 32'h0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;
`endif

  // A start request is honoured only while the loader is not mid-transfer
  // (LOAD) or mid-settle (HOLD).
  function automatic logic state_can_start(input state_e s);
    logic ok;
    ok = (s == ST_IDLE) || (s == ST_RUN);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ok = ok || (s == ST_ERR);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/imem_loader_cksum.sv
// imem_loader_cksum
//   XOR accumulator over the loaded image words. Only compiled when
//   IMEM_LOADER_CHECKSUM_EN is defined, since it is only instantiated then.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_i   : synchronous active-high reset (acc -> seed)
//     clr_i   : reload the accumulator with the seed (wins over en_i)
//     en_i    : fold data_i into the accumulator
//     data_i  : 32-bit word
//     acc_o   : current accumulated value
`ifdef IMEM_LOADER_CHECKSUM_EN
module imem_loader_cksum
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] acc_o
);

  logic [31:0] acc_q;
  logic [31:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = IMEM_LOADER_CKSUM_SEED;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= IMEM_LOADER_CKSUM_SEED;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`endif

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Accepts a stream of 32-bit instruction words
//   over valid/ready and writes them to instruction memory at word addresses
//   0, 1, 2, ... The CPU is held in reset until the image is written and a
//   settle delay of HOLD_CYCLES has elapsed.
//
//   Handshake: a word transfers on a rising edge where in_valid && in_ready.
//   in_ready is decoded from the state alone (high only in LOAD), so it never
//   depends on in_valid; the producer holds in_data stable while in_valid is
//   high and in_ready is low.
//
//   Parameters: DEPTH (words, must equal 2**ADDR_W), ADDR_W, HOLD_CYCLES (>=1).
//   Ports:
//     clock, reset        : rising-edge clock, synchronous active-high reset
//     start, len          : one-cycle load request and word count (saturated
//                           to DEPTH when accepted)
//     in_valid/in_ready/in_data : input word stream
//     imem_we/imem_addr/imem_wdata : registered memory write port, one cycle
//                           after each accepted word
//     cpu_hold            : 1 = CPU held in reset
//     busy                : high in LOAD and HOLD
//     done                : one-cycle pulse on the first RUN cycle
//     error               : checksum mismatch, sticky until reset/start
//   Build option: `define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
//   checksum word after the image; without it error is tied low.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int HOLD_CYCLES = IMEM_LOADER_HOLD_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_L  = HOLD_W'(HOLD_CYCLES);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;     // words written so far
  logic [LEN_W-1:0]    len_q, len_d;     // latched, saturated length
  logic [HOLD_W-1:0]   hold_q, hold_d;   // settle down-counter
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;

  logic                xfer;
  logic [LEN_W-1:0]    len_sat;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic                err_q, err_d;
  logic                cks_clr;
  logic                cks_en;
  logic [31:0]         cks_acc;

  imem_loader_cksum u_cksum (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (cks_clr),
    .en_i   (cks_en),
    .data_i (in_data),
    .acc_o  (cks_acc)
  );
`endif

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_HOLD);
  assign xfer     = in_valid && in_ready;
  assign len_sat  = (len > DEPTH_L) ? DEPTH_L : len;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hold_d     = hold_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_d      = err_q;
    cks_clr    = 1'b0;
    cks_en     = 1'b0;
`endif

    if (start && state_can_start(state_q)) begin
      len_d      = len_sat;
      cnt_d      = '0;
      cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Even an empty image is followed by a checksum word, so always LOAD.
      err_d      = 1'b0;
      cks_clr    = 1'b1;
      state_d    = ST_LOAD;
`else
      if (len_sat != '0) begin
        state_d = ST_LOAD;
      end else begin
        state_d = ST_HOLD;
        hold_d  = HOLD_L;
      end
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (cnt_q == len_q) begin
              // Trailing checksum word: compared, never written.
              if (in_data == cks_acc) begin
                state_d = ST_HOLD;
                hold_d  = HOLD_L;
              end else begin
                state_d = ST_ERR;
                err_d   = 1'b1;
              end
            end else begin
              we_d    = 1'b1;
              addr_d  = cnt_q[ADDR_W-1:0];
              wdata_d = in_data;
              cnt_d   = cnt_q + 1'b1;
              cks_en  = 1'b1;
            end
`else
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = in_data;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              state_d = ST_HOLD;
              hold_d  = HOLD_L;
            end
`endif
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d    = ST_RUN;
            cpu_hold_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hold_q     <= hold_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q      <= err_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign error      = err_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader (DEPTH=32, ADDR_W=5, HOLD_CYCLES=4).
//   Inputs are driven and outputs sampled on the falling clock edge.
//   A monitor logs every memory write with its cycle number; each test task
//   fills exp_q with the writes it expects and compares against the log.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int HOLD   = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CK_EXTRA = 1;
`else
  localparam int CK_EXTRA = 0;
`endif
  // cycles from the last write to cpu_hold low when words go back-to-back
  localparam int FALL_DLY = HOLD + 1 + CK_EXTRA;
  localparam int W        = ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .clock      (clk),
    .reset      (rst),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_cyc_q[$];
  int           cyc = 0;
  int           done_cnt = 0;
  int           fall_cyc = -1;
  logic         prev_hold = 1'b1;
  int           checks = 0;
  int           errors = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we === 1'b1) begin
      obs_q.push_back({imem_addr, imem_wdata});
      obs_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (prev_hold === 1'b1 && cpu_hold === 1'b0) fall_cyc = cyc;
    prev_hold = cpu_hold;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [ADDR_W:0] l);
    start = 1'b1;
    len   = l;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_cksum(input logic [31:0] ck);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(ck);
`else
    if (ck === 32'hx) tick(0);
`endif
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (cpu_hold !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s_release_timeout cpu_hold=%b required 0", name, cpu_hold);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %b exp 1", cpu_hold); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (imem_we !== 1'b0)  begin errors++; $display("FAIL reset_imem_we got %b exp 0", imem_we); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (error !== 1'b0)    begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    checks++; if ({imem_addr, imem_wdata} !== '0) begin errors++; $display("FAIL reset_addr_data got %h exp 0", {imem_addr, imem_wdata}); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int base, dbase;
    logic [31:0] w0, w1, w2;
    w0 = 32'h2010_0009; w1 = 32'h2011_0004; w2 = 32'h0211_9020;
    base = obs_q.size(); dbase = done_cnt;
    exp_q.delete();
    exp_q.push_back({5'd0, w0}); exp_q.push_back({5'd1, w1}); exp_q.push_back({5'd2, w2});
    do_start(6'd3);
    checks++; if ({in_ready, busy, cpu_hold} !== 3'b111) begin errors++; $display("FAIL basic_load_flags got %b exp 111", {in_ready, busy, cpu_hold}); end
    send_word(w0); send_word(w1); send_word(w2);
    send_cksum(w0 ^ w1 ^ w2);
    wait_release("basic");
    tick(2);
    checks++; if (obs_q.size() - base !== 3) begin errors++; $display("FAIL basic_wr_count got %0d exp 3", obs_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < obs_q.size()) begin
        checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL basic_wr[%0d] got %h exp %h", i, obs_q[base+i], exp_q[i]); end
      end
    end
    if (obs_q.size() - base == 3) begin
      checks++; if (obs_cyc_q[base+2] - obs_cyc_q[base] !== 2) begin errors++; $display("FAIL basic_back_to_back span got %0d exp 2", obs_cyc_q[base+2] - obs_cyc_q[base]); end
      checks++; if (fall_cyc - obs_cyc_q[base+2] !== FALL_DLY) begin errors++; $display("FAIL basic_hold_fall delay got %0d exp %0d", fall_cyc - obs_cyc_q[base+2], FALL_DLY); end
    end
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt - dbase); end
    checks++; if ({busy, error, done} !== 3'b000) begin errors++; $display("FAIL basic_run_flags got %b exp 000", {busy, error, done}); end
  endtask

  task automatic test_stall_full();
    int base;
    logic [31:0] ck, d;
    base = obs_q.size();
    ck = 32'h0;
    exp_q.delete();
    do_start(6'd32);
    for (int k = 0; k < 63; k++) begin
      if (k % 2 == 0) begin
        d = 32'hC0DE_0000 + 32'(k / 2);
        ck = ck ^ d;
        exp_q.push_back({5'(k / 2), d});
        send_word(d);
      end else begin
        tick(1);
      end
    end
    send_cksum(ck);
    wait_release("stall");
    tick(2);
    checks++; if (obs_q.size() - base !== 32) begin errors++; $display("FAIL stall_wr_count got %0d exp 32", obs_q.size() - base); end
    for (int i = 0; i < 32; i++) begin
      if (base + i < obs_q.size()) begin
        checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL stall_wr[%0d] got %h exp %h", i, obs_q[base+i], exp_q[i]); end
        if (i > 0) begin
          checks++; if (obs_cyc_q[base+i] - obs_cyc_q[base+i-1] !== 2) begin errors++; $display("FAIL stall_gap[%0d] got %0d exp 2", i, obs_cyc_q[base+i] - obs_cyc_q[base+i-1]); end
        end
      end
    end
    if (obs_q.size() - base == 32) begin
      checks++; if (fall_cyc - obs_cyc_q[base+31] !== FALL_DLY) begin errors++; $display("FAIL stall_hold_fall delay got %0d exp %0d", fall_cyc - obs_cyc_q[base+31], FALL_DLY); end
    end
  endtask

  task automatic test_saturate();
    int base;
    logic [31:0] ck, d;
    base = obs_q.size();
    ck = 32'h0;
    exp_q.delete();
    do_start(6'd45);
    for (int i = 0; i < 32; i++) begin
      d = 32'h5A00_0000 + 32'(i * 3);
      ck = ck ^ d;
      exp_q.push_back({5'(i), d});
      send_word(d);
    end
    send_cksum(ck);
    checks++; if ({in_ready, busy} !== 2'b01) begin errors++; $display("FAIL sat_after_last got ready,busy=%b exp 01", {in_ready, busy}); end
    wait_release("sat");
    tick(2);
    checks++; if (obs_q.size() - base !== 32) begin errors++; $display("FAIL sat_wr_count got %0d exp 32", obs_q.size() - base); end
    if (obs_q.size() - base >= 32) begin
      checks++; if (obs_q[base+31] !== exp_q[31]) begin errors++; $display("FAIL sat_last_wr got %h exp %h", obs_q[base+31], exp_q[31]); end
    end
  endtask

  task automatic test_mid_reset();
    int base;
    base = obs_q.size();
    exp_q.delete();
    exp_q.push_back({5'd0, 32'hAAAA_0000}); exp_q.push_back({5'd1, 32'hAAAA_0001});
    do_start(6'd5);
    send_word(32'hAAAA_0000);
    send_word(32'hAAAA_0001);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hAAAA_0002;
    tick(1);
    rst = 1'b0; in_valid = 1'b0;
    checks++; if ({in_ready, busy, cpu_hold, imem_we, done} !== 5'b00100) begin errors++; $display("FAIL midrst_flags got %b exp 00100", {in_ready, busy, cpu_hold, imem_we, done}); end
    tick(4);
    checks++; if (obs_q.size() - base !== 2) begin errors++; $display("FAIL midrst_wr_count got %0d exp 2", obs_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      if (base + i < obs_q.size()) begin
        checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL midrst_wr[%0d] got %h exp %h", i, obs_q[base+i], exp_q[i]); end
      end
    end
    // reload starts again from address 0
    base = obs_q.size();
    exp_q.delete();
    exp_q.push_back({5'd0, 32'hBBBB_0000}); exp_q.push_back({5'd1, 32'hBBBB_0001});
    do_start(6'd2);
    send_word(32'hBBBB_0000); send_word(32'hBBBB_0001);
    send_cksum(32'hBBBB_0000 ^ 32'hBBBB_0001);
    wait_release("reload");
    tick(2);
    checks++; if (obs_q.size() - base !== 2) begin errors++; $display("FAIL reload_wr_count got %0d exp 2", obs_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      if (base + i < obs_q.size()) begin
        checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL reload_wr[%0d] got %h exp %h", i, obs_q[base+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int base, dbase;
    logic [31:0] d0, d1, d2;
    d0 = 32'h1111_0000; d1 = 32'h1111_0001; d2 = 32'h1111_0002;
    // start during LOAD must not restart the counter
    base = obs_q.size(); dbase = done_cnt;
    exp_q.delete();
    exp_q.push_back({5'd0, d0}); exp_q.push_back({5'd1, d1}); exp_q.push_back({5'd2, d2});
    do_start(6'd3);
    send_word(d0);
    start = 1'b1; len = 6'd1;
    send_word(d1);
    start = 1'b0;
    send_word(d2);
    send_cksum(d0 ^ d1 ^ d2);
    wait_release("ignored");
    tick(2);
    checks++; if (obs_q.size() - base !== 3) begin errors++; $display("FAIL ignored_wr_count got %0d exp 3", obs_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < obs_q.size()) begin
        checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL ignored_wr[%0d] got %h exp %h", i, obs_q[base+i], exp_q[i]); end
      end
    end
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL ignored_done_pulses got %0d exp 1", done_cnt - dbase); end
    // zero length: straight to the settle delay
    base = obs_q.size();
    do_start(6'd0);
    send_cksum(32'h0);
    for (int i = 0; i < HOLD + 1; i++) begin
      checks++; if ({cpu_hold, busy, in_ready} !== 3'b110) begin errors++; $display("FAIL zero_hold[%0d] got hold,busy,ready=%b exp 110", i, {cpu_hold, busy, in_ready}); end
      tick(1);
    end
    checks++; if ({cpu_hold, done} !== 2'b01) begin errors++; $display("FAIL zero_release got hold,done=%b exp 01", {cpu_hold, done}); end
    tick(2);
    checks++; if (obs_q.size() - base !== 0) begin errors++; $display("FAIL zero_wr_count got %0d exp 0", obs_q.size() - base); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int base, dbase;
    // matching checksum
    dbase = done_cnt;
    do_start(6'd2);
    send_word(32'h1); send_word(32'h2); send_word(32'h3);
    wait_release("cksum_ok");
    tick(1);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL cksum_ok_error got %b exp 0", error); end
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL cksum_ok_done got %0d exp 1", done_cnt - dbase); end
    // mismatching checksum
    base = obs_q.size(); dbase = done_cnt;
    exp_q.delete();
    exp_q.push_back({5'd0, 32'h1}); exp_q.push_back({5'd1, 32'h2});
    do_start(6'd2);
    send_word(32'h1); send_word(32'h2); send_word(32'h4);
    tick(10);
    checks++; if ({error, cpu_hold, busy, in_ready} !== 4'b1100) begin errors++; $display("FAIL cksum_bad_flags got %b exp 1100", {error, cpu_hold, busy, in_ready}); end
    checks++; if (done_cnt - dbase !== 0) begin errors++; $display("FAIL cksum_bad_done got %0d exp 0", done_cnt - dbase); end
    checks++; if (obs_q.size() - base !== 2) begin errors++; $display("FAIL cksum_bad_wr_count got %0d exp 2", obs_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      if (base + i < obs_q.size()) begin
        checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL cksum_bad_wr[%0d] got %h exp %h", i, obs_q[base+i], exp_q[i]); end
      end
    end
    // a new start clears the error
    do_start(6'd0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL cksum_clear_error got %b exp 0", error); end
    send_word(32'h0);
    wait_release("cksum_clear");
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_stall_full();
    test_saturate();
    test_mid_reset();
    test_zero_and_ignored_start();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
